// File: rtl/prop_window_checker.sv
// Multi-channel implication/window property checker: each antecedent opens an obligation that the
// consequent must (MODE 0) or must not (MODE 1) appear within [MIN_DLY, MAX_DLY] cycles.
module prop_window_checker #(
  parameter int CH      = 1,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 3,
  parameter int MODE    = 0,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CH-1:0]         dis,
  input  logic [CH-1:0]         ante,
  input  logic [CH-1:0]         cons,
  input  logic                  clr_cnt,
  output logic [CH-1:0]         pass,
  output logic [CH-1:0]         fail,
  output logic [CH-1:0]         pending,
  output logic [CH*CNT_W-1:0]   fail_cnt,
  output logic                  err_sticky
);

  // Registered ages start at 1; keep at least one bit so a zero-delay window still elaborates.
  localparam int AW = (MAX_DLY < 1) ? 1 : MAX_DLY;

  logic [CH-1:0][MAX_DLY:0] age_p0;
  logic [CH-1:0][MAX_DLY:0] ret_p0;
  logic [CH-1:0][AW:1]      age_nxt;
  logic [CH-1:0][AW:1]      age_p1;
  logic [CH-1:0]            pass_nxt;
  logic [CH-1:0]            fail_nxt;
  logic [CH-1:0]            pend_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0: current attempts by age, window evaluation and retirement
  always_comb begin
    age_p0   = '0;
    ret_p0   = '0;
    age_nxt  = '0;
    pass_nxt = '0;
    fail_nxt = '0;
    pend_nxt = '0;
    for (int i = 0; i < CH; i++) begin
      age_p0[i][0] = ante[i] & en & ~dis[i];
      for (int k = 1; k <= MAX_DLY; k++) begin
        age_p0[i][k] = age_p1[i][k] & ~dis[i];
      end
      for (int k = MIN_DLY; k <= MAX_DLY; k++) begin
        if (age_p0[i][k]) begin
          if (cons[i]) begin
            ret_p0[i][k] = 1'b1;
            if (MODE == 0) pass_nxt[i] = 1'b1;
            else           fail_nxt[i] = 1'b1;
          end else if (k == MAX_DLY) begin
            ret_p0[i][k] = 1'b1;
            if (MODE == 0) fail_nxt[i] = 1'b1;
            else           pass_nxt[i] = 1'b1;
          end
        end
      end
      for (int k = 1; k <= MAX_DLY; k++) begin
        age_nxt[i][k] = age_p0[i][k-1] & ~ret_p0[i][k-1];
      end
      pend_nxt[i] = |age_nxt[i];
    end
  end

  // Stage p1: registered ages and result pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_p1  <= '0;
      pass    <= '0;
      fail    <= '0;
      pending <= '0;
    end else begin
      age_p1  <= age_nxt;
      pass    <= pass_nxt;
      fail    <= fail_nxt;
      pending <= pend_nxt;
    end
  end

  // Stage p2: failure accounting from the registered fail pulses; clear beats a coincident fail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
    end else if (clr_cnt) begin
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (fail[i]) fail_cnt[i*CNT_W +: CNT_W] <= sat_inc(fail_cnt[i*CNT_W +: CNT_W]);
      end
      if (|fail) err_sticky <= 1'b1;
    end
  end

endmodule
